// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_ctrl_pkg : shared types, sizes and the stage address rotation        |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package fft_ctrl_pkg;

   localparam int NUM_GROUPS = 2048;
   localparam int ADDR_W     = 11;
   localparam int STAGE_W    = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Rotate the group index left by 2*stage (mod ADDR_W) bits.
   function automatic logic [ADDR_W-1:0] stage_rotl(input logic [ADDR_W-1:0] i_addr,
                                                   input logic [STAGE_W-1:0] i_stage);
      int                    amt;
      logic [2*ADDR_W-1:0]   dbl;
      amt = (2 * int'(i_stage)) % ADDR_W;
      dbl = {i_addr, i_addr} << amt;
      return dbl[2*ADDR_W-1 -: ADDR_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_addr_fifo : show-ahead FIFO holding write-back group addresses       |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module fft_addr_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == c_full_cnt);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fft4_stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft4_stage_sequencer : issues one radix-4 pass of group reads and        |
// | matches multiplier results to in-place write-back addresses. Rev 1.0     |
// +--------------------------------------------------------------------------+
module fft4_stage_sequencer
   import fft_ctrl_pkg::*;
#(
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [STAGE_W-1:0]   stage,
   input  logic                 hold,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_rd_addr,
   output logic                 mul_valid,
   output logic [ADDR_W-1:0]    mul_lable,
   input  logic                 mul_ready,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int CNT_W  = ADDR_W + 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] c_last_issue = CNT_W'(NUM_GROUPS - 1);
   localparam logic [CNT_W-1:0] c_num_groups = CNT_W'(NUM_GROUPS);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [STAGE_W-1:0]   r_stage;
   logic [CNT_W-1:0]     r_issue_cnt;
   logic [CNT_W-1:0]     r_out_cnt;
   logic [ADDR_W-1:0]    r_last_addr;
   logic                 r_err;
   logic [RD_LAT-1:0]    r_vld_dly;
   logic [ADDR_W-1:0]    r_lbl_dly [RD_LAT];

   logic                 w_busy;
   logic                 w_issue;
   logic                 w_pop;
   logic [ADDR_W-1:0]    w_rd_addr;
   logic [ADDR_W-1:0]    w_fifo_head;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [FCNT_W-1:0]    w_fifo_count;

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
      // Full is the registered occupancy, so a same-cycle pop cannot unblock issue.
      w_issue     = (r_state == S_RUN) && !hold && !w_fifo_full;
      w_pop       = mul_ready && w_busy && !w_fifo_empty;
      w_rd_addr   = stage_rotl(r_issue_cnt[ADDR_W-1:0], r_stage);
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_issue && (r_issue_cnt == c_last_issue)) w_state_nxt = S_DRAIN;
         S_DRAIN: if ((r_out_cnt == c_num_groups) && (w_fifo_count == '0)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_stage     <= '0;
         r_issue_cnt <= '0;
         r_out_cnt   <= '0;
         r_last_addr <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && start) begin
            r_stage     <= stage;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
         end else begin
            if (w_issue) begin
               r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_pop) begin
               r_out_cnt <= r_out_cnt + 1'b1;
            end
         end
         if (w_issue) begin
            r_last_addr <= w_rd_addr;
         end
         if (mul_ready && !w_pop) begin
            r_err <= 1'b1;
         end
      end
   end

   // Valid and lable ride a RD_LAT-deep pipe so they meet the bank read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_dly <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_lbl_dly[i] <= '0;
         end
      end else begin
         r_vld_dly[0] <= w_issue;
         r_lbl_dly[0] <= r_issue_cnt[ADDR_W-1:0];
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld_dly[i] <= r_vld_dly[i-1];
            r_lbl_dly[i] <= r_lbl_dly[i-1];
         end
      end
   end

   fft_addr_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_issue),
      .i_din   (w_rd_addr),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign mem_rd_en   = w_issue;
   assign mem_rd_addr = w_issue ? w_rd_addr : r_last_addr;
   assign mul_valid   = r_vld_dly[RD_LAT-1];
   assign mul_lable   = r_lbl_dly[RD_LAT-1];
   assign wr_en       = w_pop;
   assign wr_addr     = w_fifo_head;
   assign busy        = w_busy;
   assign done        = (r_state == S_DONE);
   assign err         = r_err;

endmodule
`default_nettype wire
